// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq
// Register-write sequencer that sits in front of the I2C byte engine on the
// audio shield.
//
// After reset it waits STARTUP_WAIT cycles. It then writes every (reg, data)
// pair of an external table to the codec. Each pair goes out as one 3-byte
// write: {DEV_ADDR,0}, reg, data. When the table pass is over, host
// single-register writes are served on the same engine. A NACKed transfer is
// retried up to RETRY_MAX extra times before that entry is declared failed.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   pulse: rerun the table (honoured only in IDLE)
//   rom_idx/rom_reg/rom_data table index out, table bytes in (combinational)
//   host_req/host_reg/host_data  level request plus its bytes
//   host_ack/host_err       one-cycle completion pulse plus its failure flag
//   i2c_din/i2c_copy_enable byte and load strobe to the engine
//   i2c_ready/i2c_idle/i2c_nack  engine status
//   init_done/init_err      table pass finished / some entry failed
//   busy                    sequencer is not in IDLE
module codec_cfg_seq #(
    parameter logic [6:0] DEV_ADDR     = 7'h38,
    parameter int          NUM_REGS    = 8,
    parameter int          RETRY_MAX   = 3,
    parameter int          STARTUP_WAIT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] rom_idx,
    input  logic [7:0] rom_reg,
    input  logic [7:0] rom_data,
    input  logic       host_req,
    input  logic [7:0] host_reg,
    input  logic [7:0] host_data,
    output logic       host_ack,
    output logic       host_err,
    output logic [7:0] i2c_din,
    output logic       i2c_copy_enable,
    input  logic       i2c_ready,
    input  logic       i2c_idle,
    input  logic       i2c_nack,
    output logic       init_done,
    output logic       init_err,
    output logic       busy
);
    // Startup counter runs 0..STARTUP_WAIT-1.
    localparam int CW = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(STARTUP_WAIT - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [3:0]    IDX_LAST  = (NUM_REGS > 0) ? 4'(NUM_REGS - 1) : 4'd0;
    localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        WAIT_START, IDLE, LD_ADDR, LD_REG, LD_DATA, HOLD, WAIT_IDLE, NEXT
    } state_t;

    // Which byte the last strobe carried; HOLD uses it to pick the next step.
    typedef enum logic [1:0] {SEL_ADDR, SEL_REG, SEL_DATA} sel_t;

    state_t          state, state_n;
    sel_t            byte_sel, sel_n;
    logic [CW-1:0]   wait_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            fail;       // current attempt (or final attempt) NACKed
    logic            src_host;   // current transfer belongs to the host
    logic [7:0]      host_reg_q, host_data_q;
    logic [7:0]      din_q;
    logic [3:0]      idx_q;
    logic            done_q, err_q;

    logic            begin_pass, grant, load, retry, advance, pass_end;
    logic            in_xfer, nack_hit, fail_now;
    logic [7:0]      load_byte;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_START;
            byte_sel    <= SEL_ADDR;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            fail        <= 1'b0;
            src_host    <= 1'b0;
            host_reg_q  <= 8'h00;
            host_data_q <= 8'h00;
            din_q       <= 8'h00;
            idx_q       <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == WAIT_START) wait_cnt <= wait_cnt + CW'(1);
            if (nack_hit) fail <= 1'b1;
            if (load) begin
                din_q    <= load_byte;
                byte_sel <= sel_n;
            end
            if (begin_pass) begin
                idx_q     <= 4'd0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                src_host  <= 1'b0;
                retry_cnt <= '0;
                fail      <= 1'b0;
            end
            if (grant) begin
                src_host    <= 1'b1;
                host_reg_q  <= host_reg;
                host_data_q <= host_data;
                retry_cnt   <= '0;
                fail        <= 1'b0;
            end
            // Placed after nack_hit so a retry always starts with a clean flag.
            if (retry) begin
                retry_cnt <= retry_cnt + RW'(1);
                fail      <= 1'b0;
            end
            if (advance) begin
                idx_q     <= idx_q + 4'd1;
                retry_cnt <= '0;
                fail      <= 1'b0;
            end
            if (state == NEXT && !src_host) begin
                if (fail)     err_q  <= 1'b1;
                if (pass_end) done_q <= 1'b1;
            end
        end
    end

    // Next-state logic and the one-cycle control strobes for the datapath.
    always_comb begin
        state_n    = state;
        sel_n      = SEL_ADDR;
        begin_pass = 1'b0;
        grant      = 1'b0;
        load       = 1'b0;
        retry      = 1'b0;
        advance    = 1'b0;
        pass_end   = 1'b0;
        load_byte  = ADDR_BYTE;
        in_xfer    = (state == LD_ADDR) || (state == LD_REG) || (state == LD_DATA) ||
                     (state == HOLD) || (state == WAIT_IDLE);
        nack_hit   = in_xfer && i2c_nack;
        fail_now   = fail || nack_hit;

        case (state)
            WAIT_START: begin
                if (wait_cnt == WAIT_LAST) begin
                    begin_pass = 1'b1;
                    state_n    = (NUM_REGS == 0) ? NEXT : LD_ADDR;
                end
            end
            IDLE: begin
                if (start) begin
                    begin_pass = 1'b1;
                    state_n    = (NUM_REGS == 0) ? NEXT : LD_ADDR;
                end else if (host_req && done_q) begin
                    grant   = 1'b1;
                    state_n = LD_ADDR;
                end
            end
            LD_ADDR, LD_REG, LD_DATA: begin
                if (state == LD_ADDR) begin
                    load_byte = ADDR_BYTE;
                    sel_n     = SEL_ADDR;
                end else if (state == LD_REG) begin
                    load_byte = src_host ? host_reg_q : rom_reg;
                    sel_n     = SEL_REG;
                end else begin
                    load_byte = src_host ? host_data_q : rom_data;
                    sel_n     = SEL_DATA;
                end
                if (nack_hit) begin
                    state_n = WAIT_IDLE;
                end else if (i2c_ready) begin
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // The engine's ready may still be high this cycle; never sample it here.
                if (nack_hit) begin
                    state_n = WAIT_IDLE;
                end else begin
                    case (byte_sel)
                        SEL_ADDR: state_n = LD_REG;
                        SEL_REG:  state_n = LD_DATA;
                        default:  state_n = WAIT_IDLE;
                    endcase
                end
            end
            WAIT_IDLE: begin
                if (i2c_idle) begin
                    if (fail_now && (retry_cnt < RETRY_LIM)) begin
                        retry   = 1'b1;
                        state_n = LD_ADDR;
                    end else begin
                        state_n = NEXT;
                    end
                end
            end
            NEXT: begin
                if (src_host) begin
                    state_n = IDLE;
                end else if (NUM_REGS == 0 || idx_q == IDX_LAST) begin
                    pass_end = 1'b1;
                    state_n  = IDLE;
                end else begin
                    advance = 1'b1;
                    state_n = LD_ADDR;
                end
            end
            default: state_n = WAIT_START;
        endcase
    end

    // Outputs. The strobe is the HOLD cycle itself. HOLD is entered only from a
    // successful load, so the strobe lands one cycle after ready was sampled.
    always_comb begin
        i2c_copy_enable = (state == HOLD);
        busy            = (state != IDLE);
        host_ack        = (state == NEXT) && src_host;
        host_err        = (state == NEXT) && src_host && fail;
        i2c_din         = din_q;
        rom_idx         = idx_q;
        init_done       = done_q;
        init_err        = err_q;
    end

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Register-write sequencer in front of the `i2c` byte engine on the audio shield. After reset it walks an external table of (register, data) pairs and writes each one to the codec as a 3-byte I2C write: device address, register, data. Once the table completes, it grants the same engine to host (GLU) single-register writes. It drives the engine's byte-load handshake, retries NACKed transfers, and reports completion and errors.

## Interface
Parameters:
- `DEV_ADDR`, 7'h38: 7-bit codec address; the first byte sent is {DEV_ADDR,1'b0} = 8'h70.
- `NUM_REGS`, 8: number of table entries, 0..16.
- `RETRY_MAX`, 3: extra attempts after a NACK before an entry is declared failed.
- `STARTUP_WAIT`, 1000: clk cycles between reset release and the first transfer. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that reruns the table from entry 0.
- `rom_idx`  out  4  table entry index.
- `rom_reg`  in  8  register byte for `rom_idx`, valid combinationally.
- `rom_data`  in  8  data byte for `rom_idx`, valid combinationally.
- `host_req`  in  1  level request; held until `host_ack`.
- `host_reg`  in  8  host register byte, stable while `host_req`=1.
- `host_data`  in  8  host data byte, stable while `host_req`=1.
- `host_ack`  out  1  one-cycle pulse when the host write finishes.
- `host_err`  out  1  valid with `host_ack`; 1 = failed after retries.
- `i2c_din`  out  8  byte to the engine (its DIN).
- `i2c_copy_enable`  out  1  one-cycle load strobe (the engine's copy_enable).
- `i2c_ready`  in  1  engine can accept the next byte.
- `i2c_idle`  in  1  engine has sent STOP and the bus is free.
- `i2c_nack`  in  1  one-cycle pulse when the slave NACKs a byte.
- `init_done`  out  1  table pass finished, whether or not it succeeded.
- `init_err`  out  1  at least one entry failed in the last pass.
- `busy`  out  1  sequencer is not in IDLE.

## Operation
- States: WAIT_START, IDLE, LD_ADDR, LD_REG, LD_DATA, HOLD, WAIT_IDLE, NEXT.
- WAIT_START: counts STARTUP_WAIT cycles, then clears `rom_idx`, `init_done` and `init_err`. Goes to NEXT if NUM_REGS=0, otherwise to LD_ADDR with source = table.
- LD_ADDR / LD_REG / LD_DATA: wait for `i2c_ready`=1, drive `i2c_din` and pulse `i2c_copy_enable`, then go to HOLD. The bytes are 8'h70, then `rom_reg`/`host_reg`, then `rom_data`/`host_data`.
- HOLD: lasts one cycle, in which `i2c_ready` is ignored. It returns to the next LD_* state, or to WAIT_IDLE after the data byte.
- WAIT_IDLE: waits for `i2c_idle`=1. Nothing is loaded here, so the engine issues STOP.
- NACK handling: an `i2c_nack` in any LD_*/HOLD/WAIT_IDLE state stops further loads and goes to WAIT_IDLE with a failure flag set.
  - On idle with the failure flag set: if retries < RETRY_MAX, increment the retry count and restart at LD_ADDR with the same entry. Otherwise the entry failed.
  - The retry count clears per entry.
- NEXT, table source: a failed entry sets `init_err` and the pass continues. If `rom_idx`=NUM_REGS-1 (or NUM_REGS=0), set `init_done` and go to IDLE; otherwise increment `rom_idx` and go to LD_ADDR.
- NEXT, host source: pulse `host_ack`, with `host_err`=failure, and go to IDLE.
- IDLE priority: `start` runs first and reruns the table from WAIT_START's exit point (clear flags, `rom_idx`=0, no startup wait). Otherwise, `host_req` with `init_done`=1 is latched and the host write begins.
- `start` is ignored outside IDLE. `host_req` is not serviced before `init_done`.

## Timing
- Reset values: `rom_idx`=0, `i2c_din`=0, `i2c_copy_enable`=0, `host_ack`=0, `host_err`=0, `init_done`=0, `init_err`=0, `busy`=1. State = WAIT_START.
- Reset mid-transfer takes effect at the next edge. No further strobes are issued; the engine is reset by the same signal.
- `i2c_copy_enable` goes high in the cycle after `i2c_ready` is sampled high, while in an LD_* state. `i2c_din` is valid in that same cycle and is held until the next load.
- Byte strobes are at least 2 cycles apart (LD + HOLD).
- The engine must drop `i2c_ready` within 1 cycle of the strobe.
- `host_ack` fires 1 cycle after `i2c_idle` is seen in WAIT_IDLE for a host transfer. `host_reg`/`host_data` are latched at grant.
- `busy`=0 only in IDLE.

## Test plan
- Reset, NUM_REGS=2, table {25→AA, 0F→01}, slave always ACKs → strobes carry 70,25,AA then 70,0F,01. The first strobe comes at STARTUP_WAIT+1 cycles or later. `init_done`=1, `init_err`=0, `busy`=0.
- Same table, NACK on the first data byte of entry 0 twice → three transfers of 70,25,AA, then entry 1. `init_err`=0.
- NACK every attempt on entry 0 → RETRY_MAX+1 attempts, then entry 1 still sent. Final `init_done`=1, `init_err`=1.
- After init, `host_req` with reg 42, data 5A → strobes 70,42,5A, then one `host_ack` pulse with `host_err`=0 after `i2c_idle`.
- `host_req` asserted during init, and `start` together with `host_req` in IDLE → the host is not served until the table completes; `start` wins the IDLE tie, and the host is then served after the rerun.
- Reset asserted between the REG and DATA strobes → the next cycle shows all outputs at reset values, with no stray `i2c_copy_enable` pulse.
